vec_axis_host: RTL

VEC_AXIS_HOST -- requirements
Module: vec_axis_host

---
 rtl/vec_axis_host.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vec_axis_host.sv
// Host-side AXI-Stream sequencer: streams a small input vector out on M_AXIS,
// collects the result vector from S_AXIS, and exposes it through a read port.
module vec_axis_host #(
    parameter int IN_LEN  = 3,
    parameter int OUT_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(IN_LEN)-1:0]  wr_addr,
    input  logic [31:0]                wr_data,
    input  logic                       start,
    output logic [31:0]                M_AXIS_TDATA,
    output logic                       M_AXIS_TLAST,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    input  logic [31:0]                S_AXIS_TDATA,
    input  logic                       S_AXIS_TLAST,
    input  logic                       S_AXIS_TVALID,
    output logic                       S_AXIS_TREADY,
    input  logic [$clog2(OUT_LEN)-1:0] rd_addr,
    output logic [31:0]                rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err_last
);

    localparam int TW = $clog2(IN_LEN);
    localparam int RW = $clog2(OUT_LEN);
    localparam logic [TW-1:0] TX_LAST = TW'(IN_LEN - 1);
    localparam logic [RW-1:0] RX_LAST = RW'(OUT_LEN - 1);
    localparam logic [TW-1:0] TX_ONE  = TW'(1);
    localparam logic [RW-1:0] RX_ONE  = RW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tx_idx_q, tx_idx_d;
    logic [RW-1:0]   rx_idx_q, rx_idx_d;
    logic            err_last_q, err_last_d;

    logic [31:0]     inbuf_q  [IN_LEN];
    logic [31:0]     outbuf_q [OUT_LEN];
    logic [IN_LEN-1:0]  in_we;
    logic [OUT_LEN-1:0] out_we;

    logic in_wr_ok;
    logic rx_hs;

    // Input buffer is host-writable only while idle, so a running transfer
    // always sends a consistent snapshot.
    assign in_wr_ok = (state_q == IDLE) && wr_en && (int'(wr_addr) < IN_LEN);
    assign rx_hs    = (state_q == RECV) && S_AXIS_TVALID;

    for (genvar gi = 0; gi < IN_LEN; gi++) begin : g_in_we
        assign in_we[gi] = in_wr_ok && (wr_addr == TW'(gi));
    end

    for (genvar gi = 0; gi < OUT_LEN; gi++) begin : g_out_we
        assign out_we[gi] = rx_hs && (rx_idx_q == RW'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IN_LEN; i++) begin
                inbuf_q[i] <= '0;
            end
            for (int i = 0; i < OUT_LEN; i++) begin
                outbuf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_LEN; i++) begin
                if (in_we[i]) begin
                    inbuf_q[i] <= wr_data;
                end
            end
            for (int i = 0; i < OUT_LEN; i++) begin
                if (out_we[i]) begin
                    outbuf_q[i] <= S_AXIS_TDATA;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_idx_q   <= '0;
            rx_idx_q   <= '0;
            err_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            err_last_q <= err_last_d;
        end
    end

    // Index counters stop at the final element instead of incrementing,
    // so they never wrap inside a transaction.
    always_comb begin
        state_d    = state_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        err_last_d = err_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_idx_d   = '0;
                    rx_idx_d   = '0;
                    err_last_d = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (M_AXIS_TREADY) begin
                    if (tx_idx_q == TX_LAST) begin
                        state_d = RECV;
                    end else begin
                        tx_idx_d = tx_idx_q + TX_ONE;
                    end
                end
            end
            RECV: begin
                if (S_AXIS_TVALID) begin
                    if (rx_idx_q == RX_LAST) begin
                        state_d = DONE;
                        if (!S_AXIS_TLAST) begin
                            err_last_d = 1'b1;
                        end
                    end else if (S_AXIS_TLAST) begin
                        err_last_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        rx_idx_d = rx_idx_q + RX_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign M_AXIS_TVALID = (state_q == SEND);
    assign M_AXIS_TDATA  = (state_q == SEND) ? inbuf_q[tx_idx_q] : '0;
    assign M_AXIS_TLAST  = (state_q == SEND) && (tx_idx_q == TX_LAST);
    assign S_AXIS_TREADY = (state_q == RECV);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err_last      = err_last_q;
    assign rd_data       = (int'(rd_addr) < OUT_LEN) ? outbuf_q[rd_addr] : '0;

endmodule
